// File: rtl/pr_cmd_if.sv
// Host command bus for the PR region sequencer: one-cycle command strobe
// with a registered accept/reject pulse in return.
interface pr_cmd_if;
   logic       cmd_valid;
   logic [3:0] cmd_region;
   logic [1:0] cmd_op;
   logic       cmd_ack;
   logic       cmd_nack;

   modport master (
      output cmd_valid, cmd_region, cmd_op,
      input  cmd_ack, cmd_nack
   );

   modport slave (
      input  cmd_valid, cmd_region, cmd_op,
      output cmd_ack, cmd_nack
   );
endinterface

// File: rtl/pr_region_sequencer.sv
// Per-region freeze / reset / unfreeze sequencer for partial-reconfiguration
// regions, driven by host commands, with sticky illegal-request and timeout flags.
module pr_region_sequencer #(
   parameter int N_REGIONS      = 2,
   parameter int RESET_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   pr_cmd_if.slave                cmd,
   input  logic [N_REGIONS-1:0]   freeze_status,
   input  logic [N_REGIONS-1:0]   unfreeze_status,
   input  logic [2*N_REGIONS-1:0] illegal_req,
   output logic [N_REGIONS-1:0]   freeze_req,
   output logic [N_REGIONS-1:0]   unfreeze_req,
   output logic [N_REGIONS-1:0]   pr_reset,
   output logic [3*N_REGIONS-1:0] region_state,
   output logic [2*N_REGIONS-1:0] illegal_sticky,
   output logic [N_REGIONS-1:0]   timeout_err,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_RUN        = 3'd0,
      S_FRZ_WAIT   = 3'd1,
      S_FROZEN     = 3'd2,
      S_RST        = 3'd3,
      S_UNFRZ_WAIT = 3'd4,
      S_ERROR      = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      OP_NOP       = 2'b00,
      OP_FREEZE    = 2'b01,
      OP_UNFREEZE  = 2'b10,
      OP_CLEAR_ERR = 2'b11
   } op_e;

   localparam bit             TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e                 state_q [N_REGIONS];
   state_e                 state_d [N_REGIONS];
   logic [CNT_W-1:0]       cnt_q   [N_REGIONS];
   logic [CNT_W-1:0]       cnt_d   [N_REGIONS];
   logic [N_REGIONS-1:0]   hit, clr, timeout_d;
   logic [2*N_REGIONS-1:0] sticky_d;
   logic                   ack_d, nack_d, busy_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      hit       = '0;
      clr       = '0;
      timeout_d = timeout_err;
      sticky_d  = illegal_sticky;
      ack_d     = 1'b0;
      busy_d    = 1'b0;
      for (int i = 0; i < N_REGIONS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         hit[i]     = cmd.cmd_valid && (cmd.cmd_region == 4'(i));
         clr[i]     = hit[i] && (cmd.cmd_op == OP_CLEAR_ERR);
         if (clr[i]) begin
            timeout_d[i] = 1'b0;
            ack_d        = 1'b1;
         end

         case (state_q[i])
            S_RUN: if (hit[i] && cmd.cmd_op == OP_FREEZE) begin
               state_d[i] = S_FRZ_WAIT;
               cnt_d[i]   = '0;
               ack_d      = 1'b1;
            end
            // Status sampled in the final wait cycle still beats the timeout.
            S_FRZ_WAIT: begin
               if (freeze_status[i]) begin
                  state_d[i] = S_FROZEN;
               end else if (TO_EN && cnt_q[i] == TO_LAST) begin
                  state_d[i]   = S_ERROR;
                  timeout_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            S_FROZEN: if (hit[i] && cmd.cmd_op == OP_UNFREEZE) begin
               state_d[i] = S_RST;
               cnt_d[i]   = '0;
               ack_d      = 1'b1;
            end
            S_RST: begin
               if (cnt_q[i] == RST_LAST) begin
                  state_d[i] = S_UNFRZ_WAIT;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            S_UNFRZ_WAIT: begin
               if (unfreeze_status[i]) begin
                  state_d[i] = S_RUN;
               end else if (TO_EN && cnt_q[i] == TO_LAST) begin
                  state_d[i]   = S_ERROR;
                  timeout_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            S_ERROR: if (clr[i]) state_d[i] = S_FROZEN;
            default: state_d[i] = S_RUN;
         endcase

         // A new illegal_req pulse wins over a same-cycle CLEAR_ERR.
         sticky_d[2*i +: 2] = (clr[i] ? 2'b00 : illegal_sticky[2*i +: 2])
                              | illegal_req[2*i +: 2];
         if (state_d[i] inside {S_FRZ_WAIT, S_RST, S_UNFRZ_WAIT}) busy_d = 1'b1;
      end
      nack_d = cmd.cmd_valid && !ack_d;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REGIONS; i++) begin
            state_q[i] <= S_RUN;
            cnt_q[i]   <= '0;
         end
         freeze_req     <= '0;
         unfreeze_req   <= '0;
         pr_reset       <= '0;
         illegal_sticky <= '0;
         timeout_err    <= '0;
         busy           <= 1'b0;
         cmd.cmd_ack    <= 1'b0;
         cmd.cmd_nack   <= 1'b0;
      end else begin
         for (int i = 0; i < N_REGIONS; i++) begin
            state_q[i]      <= state_d[i];
            cnt_q[i]        <= cnt_d[i];
            freeze_req[i]   <= state_d[i] inside {S_FRZ_WAIT, S_FROZEN, S_RST, S_ERROR};
            unfreeze_req[i] <= (state_d[i] == S_UNFRZ_WAIT);
            pr_reset[i]     <= (state_d[i] == S_RST);
         end
         illegal_sticky <= sticky_d;
         timeout_err    <= timeout_d;
         busy           <= busy_d;
         cmd.cmd_ack    <= ack_d;
         cmd.cmd_nack   <= nack_d;
      end
   end

   always_comb begin
      region_state = '0;
      for (int i = 0; i < N_REGIONS; i++) region_state[3*i +: 3] = state_q[i];
   end

endmodule
